// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_Tx serializer between NUM_REQ byte producers.
// Latency: request sampled at edge n -> ack/txStart high for cycle n+1 only; next grant >= 2 cycles after done.
// Backpressure: requesters hold i_req until their one-cycle ack; requests are ignored while a frame is in flight.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_DATA_BITS = 8,
  parameter int TIMEOUT_CLKS  = 4096
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [NUM_REQ*NUM_DATA_BITS-1:0] i_data,
  output logic [NUM_REQ-1:0]               o_ack,
  output logic [2:0]                       o_grantIdx,
  output logic                             o_busy,
  output logic                             o_txStart,
  output logic [NUM_DATA_BITS-1:0]         o_txByte,
  input  logic                             i_txDoneStrobe,
  output logic                             o_timeoutFlag
);

  // IDLE waits for requests, WAIT_DONE covers the serializer frame, GAP lets
  // UART_Tx settle through its post-stop state before the next start.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_DONE = 2'b01,
    GAP       = 2'b10
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CLKS - 1);

  state_t                     state;
  state_t                     stateNext;
  logic [2:0]                 pointer;
  logic [2:0]                 pointerNext;
  logic [15:0]                watchdog;
  logic [15:0]                watchdogNext;
  logic [NUM_REQ-1:0]         ackNext;
  logic                       txStartNext;
  logic [NUM_DATA_BITS-1:0]   txByteNext;
  logic                       busyNext;
  logic [2:0]                 grantIdxNext;
  logic                       timeoutFlagNext;

  logic                       anyReq;
  logic                       found;
  logic [2:0]                 winIdx;
  logic [NUM_DATA_BITS-1:0]   winByte;
  int                         cand;

  assign anyReq = |i_req;

  // Round-robin search: first set request at or above the pointer, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winIdx = pointer;
    cand   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(pointer) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == cand) && i_req[j]) begin
          found  = 1'b1;
          winIdx = 3'(j);
        end
      end
    end
  end

  // Select the winner's byte out of the packed data bus.
  always_comb begin
    winByte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winIdx == 3'(k)) begin
        winByte = i_data[k*NUM_DATA_BITS +: NUM_DATA_BITS];
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    stateNext       = state;
    pointerNext     = pointer;
    watchdogNext    = watchdog;
    ackNext         = '0;
    txStartNext     = 1'b0;
    txByteNext      = o_txByte;
    busyNext        = o_busy;
    grantIdxNext    = o_grantIdx;
    timeoutFlagNext = o_timeoutFlag;

    case (state)
      IDLE: begin
        busyNext = 1'b0;
        if (anyReq && found) begin
          for (int j = 0; j < NUM_REQ; j++) begin
            ackNext[j] = (winIdx == 3'(j));
          end
          txStartNext  = 1'b1;
          txByteNext   = winByte;
          grantIdxNext = winIdx;
          busyNext     = 1'b1;
          pointerNext  = (winIdx == LAST_IDX) ? 3'd0 : winIdx + 3'd1;
          watchdogNext = '0;
          stateNext    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // Done has priority over a timeout landing on the same cycle.
        if (i_txDoneStrobe) begin
          stateNext = GAP;
        end else if (watchdog == WD_LAST) begin
          timeoutFlagNext = 1'b1;
          stateNext       = GAP;
        end else begin
          watchdogNext = watchdog + 16'd1;
        end
      end

      GAP: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end

      default: begin
        // Corrupted state register: recover to IDLE and leave a sticky trace.
        timeoutFlagNext = 1'b1;
        busyNext        = 1'b0;
        stateNext       = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      pointer       <= '0;
      watchdog      <= '0;
      o_ack         <= '0;
      o_txStart     <= 1'b0;
      o_txByte      <= '0;
      o_busy        <= 1'b0;
      o_grantIdx    <= '0;
      o_timeoutFlag <= 1'b0;
    end else begin
      state         <= stateNext;
      pointer       <= pointerNext;
      watchdog      <= watchdogNext;
      o_ack         <= ackNext;
      o_txStart     <= txStartNext;
      o_txByte      <= txByteNext;
      o_busy        <= busyNext;
      o_grantIdx    <= grantIdxNext;
      o_timeoutFlag <= timeoutFlagNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-plus-random bench for uart_tx_arbiter against a round-robin reference model.
// Latency: checks grant one cycle after request sampling and busy release two cycles after done.
// Backpressure: the bench plays both the producers (hold/drop request) and a stub serializer.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  logic             i_clk;
  logic             i_reset;
  logic [N-1:0]     i_req;
  logic [N*W-1:0]   i_data;
  logic [N-1:0]     o_ack;
  logic [2:0]       o_grantIdx;
  logic             o_busy;
  logic             o_txStart;
  logic [W-1:0]     o_txByte;
  logic             i_txDoneStrobe;
  logic             o_timeoutFlag;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int           ptrM;
  logic [N-1:0] reqM;
  logic [W-1:0] bytesM [N];
  logic [W-1:0] latchedByte;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .NUM_DATA_BITS(W),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_req(i_req),
    .i_data(i_data),
    .o_ack(o_ack),
    .o_grantIdx(o_grantIdx),
    .o_busy(o_busy),
    .o_txStart(o_txStart),
    .o_txByte(o_txByte),
    .i_txDoneStrobe(i_txDoneStrobe),
    .o_timeoutFlag(o_timeoutFlag)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round robin from the specification: first requester at or after the pointer, modulo N.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic applyData();
    for (int k = 0; k < N; k++) i_data[k*W +: W] = bytesM[k];
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".ack"},   32'(o_ack), 32'd0);
    check({tag, ".start"}, 32'(o_txStart), 32'd0);
    check({tag, ".byte"},  32'(o_txByte), 32'd0);
    check({tag, ".busy"},  32'(o_busy), 32'd0);
    check({tag, ".idx"},   32'(o_grantIdx), 32'd0);
    check({tag, ".flag"},  32'(o_timeoutFlag), 32'd0);
  endtask

  // Sample the pending request (arbiter in IDLE) and check the grant cycle.
  task automatic grantStep(output int idx);
    int e;
    e = pick(reqM, ptrM);
    if (e < 0) e = 0;
    idx = e;
    latchedByte = bytesM[e];
    tick();
    check("grant.ack",   32'(o_ack), 32'(1) << e);
    check("grant.start", 32'(o_txStart), 32'd1);
    check("grant.idx",   32'(o_grantIdx), 32'(e));
    check("grant.byte",  32'(o_txByte), 32'(latchedByte));
    check("grant.busy",  32'(o_busy), 32'd1);
    ptrM = (e + 1) % N;
  endtask

  // One full frame: grant, len cycles in flight, done strobe, GAP, back in IDLE.
  task automatic serveFrame(input int len, input bit hold, input bit scramble);
    int idx;
    grantStep(idx);
    if (!hold) reqM[idx] = 1'b0;
    i_req = reqM;
    if (scramble) begin
      for (int k = 0; k < N; k++) bytesM[k] = W'($urandom);
      applyData();
    end
    for (int c = 1; c < len; c++) begin
      tick();
      check("frame.ack",   32'(o_ack), 32'd0);
      check("frame.start", 32'(o_txStart), 32'd0);
      check("frame.byte",  32'(o_txByte), 32'(latchedByte));
    end
    i_txDoneStrobe = 1'b1;
    tick();
    i_txDoneStrobe = 1'b0;
    check("gap.busy", 32'(o_busy), 32'd1);
    check("gap.byte", 32'(o_txByte), 32'(latchedByte));
    tick();
    check("idle.busy", 32'(o_busy), 32'd0);
    check("idle.ack",  32'(o_ack), 32'd0);
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    ptrM = 0;
  endtask

  initial begin
    int idx;
    i_reset        = 1'b1;
    i_req          = '0;
    i_data         = '0;
    i_txDoneStrobe = 1'b0;
    reqM           = '0;
    ptrM           = 0;
    for (int k = 0; k < N; k++) bytesM[k] = '0;
    @(negedge i_clk);
    tick();
    i_reset = 1'b0;
    checkIdleOutputs("reset");

    // Stray done in IDLE is ignored.
    i_txDoneStrobe = 1'b1;
    tick();
    i_txDoneStrobe = 1'b0;
    check("stray.busy", 32'(o_busy), 32'd0);
    check("stray.flag", 32'(o_timeoutFlag), 32'd0);

    // Single request, byte A5.
    bytesM[0] = 8'hA5;
    applyData();
    reqM = 4'b0001;
    i_req = reqM;
    serveFrame(12, 1'b0, 1'b0);

    // Simultaneous held requests from pointer 0: 11,22,33,44,11.
    doReset();
    bytesM[0] = 8'h11; bytesM[1] = 8'h22; bytesM[2] = 8'h33; bytesM[3] = 8'h44;
    applyData();
    reqM = 4'b1111;
    i_req = reqM;
    for (int f = 0; f < 5; f++) serveFrame(8 + f, 1'b1, 1'b0);

    // Fairness: move pointer to 2, then requesters 0 and 1.
    reqM = 4'b0010;
    i_req = reqM;
    serveFrame(5, 1'b0, 1'b0);
    reqM = 4'b0011;
    i_req = reqM;
    serveFrame(6, 1'b0, 1'b0);
    serveFrame(3, 1'b0, 1'b0);

    // Randomized traffic.
    for (int r = 0; r < 24; r++) begin
      if (reqM == '0) reqM = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) bytesM[k] = W'($urandom);
      applyData();
      i_req = reqM;
      serveFrame(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset mid-frame: pointer would be 2 afterwards without the reset.
    reqM = 4'b0010;
    i_req = reqM;
    grantStep(idx);
    reqM = '0;
    i_req = reqM;
    repeat (5) tick();
    doReset();
    checkIdleOutputs("midreset");
    reqM = 4'b1010;
    i_req = reqM;
    serveFrame(7, 1'b0, 1'b0);

    // Timeout: no done strobe ever arrives.
    reqM = 4'b0100;
    i_req = reqM;
    grantStep(idx);
    reqM = '0;
    i_req = reqM;
    repeat (TO - 1) tick();
    check("to.before.flag", 32'(o_timeoutFlag), 32'd0);
    check("to.before.busy", 32'(o_busy), 32'd1);
    tick();
    check("to.flag", 32'(o_timeoutFlag), 32'd1);
    tick();
    check("to.idle.busy", 32'(o_busy), 32'd0);
    reqM = 4'b1001;
    i_req = reqM;
    serveFrame(10, 1'b0, 1'b0);
    check("to.sticky", 32'(o_timeoutFlag), 32'd1);

    // Done exactly on the last watchdog count: done wins.
    doReset();
    check("co.reset.flag", 32'(o_timeoutFlag), 32'd0);
    reqM = 4'b0001;
    i_req = reqM;
    grantStep(idx);
    reqM = '0;
    i_req = reqM;
    repeat (TO - 1) tick();
    i_txDoneStrobe = 1'b1;
    tick();
    i_txDoneStrobe = 1'b0;
    check("co.flag", 32'(o_timeoutFlag), 32'd0);
    check("co.busy", 32'(o_busy), 32'd1);
    tick();
    check("co.idle.busy", 32'(o_busy), 32'd0);
    check("co.idle.flag", 32'(o_timeoutFlag), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
